wb_select_stage: RTL and testbench
==================================

# wb_select_stage

Registered, parametrised write-back selector for the pipeline's WB stage. It picks the register-file write value from NSRC execute-side lanes, a memory-load lane, or a link address (PC + LINK_OFFSET into LINK_REG, for JAL/JALR). It replaces the fixed two-input PC/register select. It adds a valid/ready handshake, a wait state for late memory data, flush, and r0 write suppression.

## Interface
Parameters:
- DATA_W, 32, datapath width
- NSRC, 4, number of execute-side source lanes
- REG_AW, 5, register-address width
- LINK_OFFSET, 8, added to in_pc for the link value
- LINK_REG, 31, destination forced on link

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  upstream instruction present
- in_ready  out  1  stage can accept; high only in IDLE
- in_sel  in  $clog2(NSRC+1)  0..NSRC-1 selects a lane; NSRC selects mem_data
- in_data  in  NSRC*DATA_W  flattened lanes, lane k at [k*DATA_W +: DATA_W]
- in_pc  in  DATA_W  PC of the instruction
- in_link  in  1  link override
- in_rd  in  REG_AW  destination register
- in_wen  in  1  instruction writes a register
- mem_data  in  DATA_W  load result
- mem_ready  in  1  mem_data valid this cycle
- flush  in  1  discard pending and incoming work
- out_valid  out  1  one-cycle commit pulse
- out_data  out  DATA_W  write value
- out_rd  out  REG_AW  write address
- out_wen  out  1  register-file write enable

## Operation
- Accept occurs when in_valid && in_ready.
- Selection on accept, in priority order:
  - in_link=1: data = in_pc + LINK_OFFSET (mod 2^DATA_W), rd = LINK_REG. in_sel is ignored.
  - in_sel < NSRC: data = lane in_sel.
  - in_sel == NSRC: data = mem_data.
  - in_sel > NSRC: data = 0.
- FSM states: IDLE, WAIT_MEM.
  - IDLE, accept, mem selected, mem_ready=0: latch rd and wen, go to WAIT_MEM, no commit.
  - IDLE, accept, any other case: commit next edge, stay in IDLE.
  - WAIT_MEM, mem_ready=1: commit mem_data with the latched rd/wen, return to IDLE.
  - WAIT_MEM, mem_ready=0: hold.
- A commit sets out_valid=1 for exactly one cycle. out_wen = out_valid && wen && (rd != 0).
- No downstream backpressure exists.
- flush (any state) takes priority over accept and over mem_ready:
  - next edge: out_valid=0, out_wen=0, state IDLE;
  - the pending load is dropped; input in the same cycle is dropped.
- Reset values: out_valid 0, out_data 0, out_rd 0, out_wen 0, state IDLE. in_ready follows state, so it is 1 after reset.
- Reset asserted mid-WAIT_MEM abandons the load silently.

## Timing
- Non-memory or link source: commit 1 cycle after accept.
- Memory source with mem_ready high in the accept cycle: 1 cycle.
- Memory source otherwise: commit on the edge after the first cycle mem_ready=1 is sampled in WAIT_MEM.
- in_ready is registered-state-derived; there is no combinational path from in_valid.
- out_data/out_rd hold their last committed value when out_valid=0.
- Back-to-back accepts in IDLE give one commit per cycle.

## Configuration
- WB_FWD_EN defined:
  - Adds outputs fwd_valid, fwd_rd, fwd_data. These hold the most recent committed write (only commits with out_wen=1) until the next such write.
  - fwd_valid is cleared by reset and flush.
  - The hazard unit uses them to forward one extra cycle.
- WB_FWD_EN undefined: the ports and registers do not exist. Behaviour is otherwise identical.

## Structure
- Package wb_pkg holds:
  - the state enum (IDLE, WAIT_MEM);
  - source-index constants SRC_ALU=0, SRC_SHIFT=1, SRC_HI=2, SRC_LO=3;
  - LINK_REG/LINK_OFFSET defaults.
- Sub-module wb_src_mux holds the combinational N-way lane select plus the link override and the out-of-range zero. It is instantiated once.

## Test plan
- Reset mid-stream, then release: outputs are all 0 and in_ready=1. Accept lane 2 = 0xDEADBEEF, rd=5 → next cycle out_valid=1, out_data=0xDEADBEEF, out_rd=5, out_wen=1.
- in_link=1, in_pc=0x00400010, in_sel=1 → out_data=0x00400018, out_rd=31.
- Load, rd=8, mem_ready low for 3 cycles then high with mem_data=0x12345678 → in_ready=0 for 3 cycles; out_valid on the following edge with 0x12345678, rd=8.
- Write to rd=0 with wen=1 → out_valid=1, out_wen=0.
- flush while in WAIT_MEM, with mem_ready=1 in the same cycle → no commit, state IDLE, in_ready=1 next cycle.
- WB_FWD_EN build, commits to rd=3 then rd=0 → fwd_rd stays 3 with the first value; flush → fwd_valid=0.

Source files
------------

// File: rtl/wb_pkg.sv
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared types and constants for the write-back select stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    localparam int SRC_ALU   = 0;
    localparam int SRC_SHIFT = 1;
    localparam int SRC_HI    = 2;
    localparam int SRC_LO    = 3;

    localparam int LINK_REG_DEF    = 31;
    localparam int LINK_OFFSET_DEF = 8;

endpackage

`default_nettype wire

// File: rtl/wb_src_mux.sv
// ============================================================================
// Module  : wb_src_mux
// Brief   : Combinational N-way lane select with link override and
//           out-of-range zero.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_src_mux #(
    parameter int DATA_W      = 32,
    parameter int NSRC        = 4,
    parameter int LINK_OFFSET = 8,
    parameter int SEL_W       = $clog2(NSRC + 1)
) (
    input  logic [SEL_W-1:0]       i_sel,
    input  logic [NSRC*DATA_W-1:0] i_lanes,
    input  logic [DATA_W-1:0]      i_mem_data,
    input  logic [DATA_W-1:0]      i_pc,
    input  logic                   i_link,
    output logic [DATA_W-1:0]      o_data
);

    localparam logic [SEL_W-1:0] c_MEM_SEL = SEL_W'(NSRC);

    // Selector codes above NSRC fall through every arm and yield zero.
    always_comb begin
        o_data = '0;
        if (i_link) begin
            o_data = i_pc + DATA_W'(LINK_OFFSET);
        end else if (i_sel == c_MEM_SEL) begin
            o_data = i_mem_data;
        end else begin
            for (int k = 0; k < NSRC; k++) begin
                if (i_sel == SEL_W'(k)) begin
                    o_data = i_lanes[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_select_stage.sv
// ============================================================================
// Module  : wb_select_stage
// Brief   : Registered WB-stage selector with handshake, load wait, flush and
//           r0 suppression. Define WB_FWD_EN to add the fwd_* outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_select_stage
    import wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NSRC        = 4,
    parameter int REG_AW      = 5,
    parameter int LINK_OFFSET = LINK_OFFSET_DEF,
    parameter int LINK_REG    = LINK_REG_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(NSRC+1)-1:0]    in_sel,
    input  logic [NSRC*DATA_W-1:0]       in_data,
    input  logic [DATA_W-1:0]            in_pc,
    input  logic                         in_link,
    input  logic [REG_AW-1:0]            in_rd,
    input  logic                         in_wen,
    input  logic [DATA_W-1:0]            mem_data,
    input  logic                         mem_ready,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [REG_AW-1:0]            out_rd,
    output logic                         out_wen
`ifdef WB_FWD_EN
    ,
    output logic                         fwd_valid,
    output logic [REG_AW-1:0]            fwd_rd,
    output logic [DATA_W-1:0]            fwd_data
`endif
);

    localparam int                 c_SEL_W   = $clog2(NSRC + 1);
    localparam logic [c_SEL_W-1:0] c_MEM_SEL = c_SEL_W'(NSRC);

    wb_state_t          r_state;
    logic [REG_AW-1:0]  r_pend_rd;
    logic               r_pend_wen;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic [REG_AW-1:0]  r_out_rd;
    logic               r_out_wen;

    logic [DATA_W-1:0]  w_sel_data;
    logic [REG_AW-1:0]  w_sel_rd;
    logic               w_accept;
    logic               w_is_mem;
    logic               w_commit;
    logic [DATA_W-1:0]  w_cdata;
    logic [REG_AW-1:0]  w_crd;
    logic               w_cwen;

    wb_src_mux #(
        .DATA_W      (DATA_W),
        .NSRC        (NSRC),
        .LINK_OFFSET (LINK_OFFSET),
        .SEL_W       (c_SEL_W)
    ) u_src_mux (
        .i_sel      (in_sel),
        .i_lanes    (in_data),
        .i_mem_data (mem_data),
        .i_pc       (in_pc),
        .i_link     (in_link),
        .o_data     (w_sel_data)
    );

    assign in_ready = (r_state == IDLE);

    // Commit decode: a pending load completes from mem_data with latched rd/wen.
    always_comb begin
        w_accept = in_valid && in_ready;
        w_is_mem = !in_link && (in_sel == c_MEM_SEL);
        w_sel_rd = in_link ? REG_AW'(LINK_REG) : in_rd;
        w_commit = 1'b0;
        w_cdata  = w_sel_data;
        w_crd    = w_sel_rd;
        w_cwen   = in_wen;
        if (!flush) begin
            if (r_state == WAIT_MEM) begin
                w_commit = mem_ready;
                w_cdata  = mem_data;
                w_crd    = r_pend_rd;
                w_cwen   = r_pend_wen;
            end else begin
                w_commit = w_accept && !(w_is_mem && !mem_ready);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pend_rd   <= '0;
            r_pend_wen  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_rd    <= '0;
            r_out_wen   <= 1'b0;
        end else begin
            r_out_valid <= w_commit;
            r_out_wen   <= w_commit && w_cwen && (w_crd != '0);
            if (w_commit) begin
                r_out_data <= w_cdata;
                r_out_rd   <= w_crd;
            end
            if (flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept && w_is_mem && !mem_ready) begin
                            r_state    <= WAIT_MEM;
                            r_pend_rd  <= in_rd;
                            r_pend_wen <= in_wen;
                        end
                    end
                    WAIT_MEM: begin
                        if (mem_ready) begin
                            r_state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_rd    = r_out_rd;
    assign out_wen   = r_out_wen;

`ifdef WB_FWD_EN
    logic               r_fwd_valid;
    logic [REG_AW-1:0]  r_fwd_rd;
    logic [DATA_W-1:0]  r_fwd_data;

    // Only real register writes are remembered for forwarding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fwd_valid <= 1'b0;
            r_fwd_rd    <= '0;
            r_fwd_data  <= '0;
        end else if (flush) begin
            r_fwd_valid <= 1'b0;
        end else if (w_commit && w_cwen && (w_crd != '0)) begin
            r_fwd_valid <= 1'b1;
            r_fwd_rd    <= w_crd;
            r_fwd_data  <= w_cdata;
        end
    end

    assign fwd_valid = r_fwd_valid;
    assign fwd_rd    = r_fwd_rd;
    assign fwd_data  = r_fwd_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_select_stage.sv
// ============================================================================
// Module  : tb_wb_select_stage
// Brief   : Directed self-checking bench for wb_select_stage (WB_FWD_EN aware).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_select_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_sel;
    logic [127:0] in_data;
    logic [31:0]  in_pc;
    logic         in_link;
    logic [4:0]   in_rd;
    logic         in_wen;
    logic [31:0]  mem_data;
    logic         mem_ready;
    logic         flush;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [4:0]   out_rd;
    logic         out_wen;
`ifdef WB_FWD_EN
    logic         fwd_valid;
    logic [4:0]   fwd_rd;
    logic [31:0]  fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    wb_select_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_pc     (in_pc),
        .in_link   (in_link),
        .in_rd     (in_rd),
        .in_wen    (in_wen),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_wen   (out_wen)
`ifdef WB_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the value a write-back of this instruction must carry.
    function automatic logic [31:0] pick(input logic [2:0] sel, input logic [127:0] lanes,
                                         input logic [31:0] pc, input logic link,
                                         input logic [31:0] mem);
        logic [127:0] sh;
        if (link) return pc + 32'd8;
        if (sel < 3'd4) begin
            sh = lanes >> (32 * sel);
            return sh[31:0];
        end
        if (sel == 3'd4) return mem;
        return 32'd0;
    endfunction

    logic        m_pend;
    logic [4:0]  m_rd;
    logic        m_wen;
    logic        e_valid, e_wen;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_fv;
    logic [4:0]  e_frd;
    logic [31:0] e_fd;

    wire         m_load  = in_valid && !in_link && (in_sel == 3'd4);
    wire         m_commit = !flush && (m_pend ? mem_ready : (in_valid && !(m_load && !mem_ready)));
    wire [31:0]  m_data  = m_pend ? mem_data : pick(in_sel, in_data, in_pc, in_link, mem_data);
    wire [4:0]   m_dst   = m_pend ? m_rd : (in_link ? 5'd31 : in_rd);
    wire         m_we    = m_pend ? m_wen : in_wen;
    wire         m_write = m_commit && m_we && (m_dst != 5'd0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend <= 1'b0; m_rd <= '0; m_wen <= 1'b0;
            e_valid <= 1'b0; e_wen <= 1'b0; e_data <= '0; e_rd <= '0;
            e_fv <= 1'b0; e_frd <= '0; e_fd <= '0;
        end else begin
            e_valid <= m_commit;
            e_wen   <= m_write;
            if (m_commit) begin
                e_data <= m_data;
                e_rd   <= m_dst;
            end
            m_pend <= !flush && (m_pend ? !mem_ready : (m_load && !mem_ready));
            if (!m_pend && in_valid) begin
                m_rd  <= in_rd;
                m_wen <= in_wen;
            end
            if (flush) e_fv <= 1'b0;
            else if (m_write) begin
                e_fv <= 1'b1; e_frd <= m_dst; e_fd <= m_data;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, !m_pend});
        chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, e_valid});
        chk("cyc_out_wen", {31'd0, out_wen}, {31'd0, e_wen});
        chk("cyc_out_data", out_data, e_data);
        chk("cyc_out_rd", {27'd0, out_rd}, {27'd0, e_rd});
`ifdef WB_FWD_EN
        chk("cyc_fwd_valid", {31'd0, fwd_valid}, {31'd0, e_fv});
        if (e_fv) begin
            chk("cyc_fwd_rd", {27'd0, fwd_rd}, {27'd0, e_frd});
            chk("cyc_fwd_data", fwd_data, e_fd);
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lane_val [4];
        lane_val[0] = 32'h11111111; lane_val[1] = 32'h22222222;
        lane_val[2] = 32'h33333333; lane_val[3] = 32'h44444444;
        reset = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; in_pc = '0;
        in_link = 1'b0; in_rd = '0; in_wen = 1'b0; mem_data = '0; mem_ready = 1'b0;
        flush = 1'b0;
        #1 reset = 1'b1;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // Reset in the middle of a load wait
        in_valid = 1'b1; in_sel = 3'd4; in_rd = 5'd8; in_wen = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_rd", {27'd0, out_rd}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);

        // Lane 2 commit
        in_data = {32'h4, 32'hDEADBEEF, 32'h2, 32'h1};
        in_valid = 1'b1; in_sel = 3'd2; in_rd = 5'd5; in_wen = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lane2_valid", {31'd0, out_valid}, 32'd1);
        chk("lane2_data", out_data, 32'hDEADBEEF);
        chk("lane2_rd", {27'd0, out_rd}, 32'd5);
        chk("lane2_wen", {31'd0, out_wen}, 32'd1);
        tick();
        chk("hold_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_data", out_data, 32'hDEADBEEF);

        // Link override
        in_valid = 1'b1; in_link = 1'b1; in_pc = 32'h00400010; in_sel = 3'd1; in_rd = 5'd4;
        tick();
        in_valid = 1'b0; in_link = 1'b0;
        chk("link_data", out_data, 32'h00400018);
        chk("link_rd", {27'd0, out_rd}, 32'd31);

        // Load with three cycles of mem_ready low
        in_valid = 1'b1; in_sel = 3'd4; in_rd = 5'd8; mem_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("load_ready_low", {31'd0, in_ready}, 32'd0);
            chk("load_no_commit", {31'd0, out_valid}, 32'd0);
            if (i < 2) tick();
        end
        mem_ready = 1'b1; mem_data = 32'h12345678;
        tick();
        mem_ready = 1'b0;
        chk("load_valid", {31'd0, out_valid}, 32'd1);
        chk("load_data", out_data, 32'h12345678);
        chk("load_rd", {27'd0, out_rd}, 32'd8);
        chk("load_ready_back", {31'd0, in_ready}, 32'd1);

        // Write to r0 is suppressed
        in_data[31:0] = 32'h00000055;
        in_valid = 1'b1; in_sel = 3'd0; in_rd = 5'd0; in_wen = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("r0_valid", {31'd0, out_valid}, 32'd1);
        chk("r0_wen", {31'd0, out_wen}, 32'd0);

        // Load with data ready in the accept cycle
        in_valid = 1'b1; in_sel = 3'd4; in_rd = 5'd9; mem_ready = 1'b1; mem_data = 32'hCAFEF00D;
        tick();
        in_valid = 1'b0; mem_ready = 1'b0;
        chk("fastload_data", out_data, 32'hCAFEF00D);
        chk("fastload_ready", {31'd0, in_ready}, 32'd1);

        // Flush in WAIT_MEM beats mem_ready
        in_valid = 1'b1; in_sel = 3'd4; in_rd = 5'd10;
        tick();
        chk("flushwait_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; mem_ready = 1'b1; mem_data = 32'h0000AAAA;
        tick();
        flush = 1'b0; mem_ready = 1'b0; in_valid = 1'b0;
        chk("flush_no_commit", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_hold_data", out_data, 32'hCAFEF00D);

        // Flush in IDLE drops the incoming instruction
        in_valid = 1'b1; in_sel = 3'd0; in_rd = 5'd6; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_drop", {31'd0, out_valid}, 32'd0);

        // Out-of-range selectors give zero
        for (int s = 5; s < 8; s++) begin
            in_valid = 1'b1; in_sel = 3'(s); in_rd = 5'd11;
            tick();
            chk("oor_data", out_data, 32'd0);
        end

        // Back-to-back lane commits, last one without wen
        in_data = {lane_val[3], lane_val[2], lane_val[1], lane_val[0]};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = 3'(i); in_rd = 5'(12 + i); in_wen = (i != 3);
            tick();
            chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_data", out_data, lane_val[i]);
            chk("b2b_wen", {31'd0, out_wen}, (i != 3) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0; in_wen = 1'b1;
        tick();

`ifdef WB_FWD_EN
        in_data[31:0] = 32'h00000333;
        in_valid = 1'b1; in_sel = 3'd0; in_rd = 5'd3;
        tick();
        in_sel = 3'd1; in_rd = 5'd0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("fwd_valid", {31'd0, fwd_valid}, 32'd1);
        chk("fwd_rd", {27'd0, fwd_rd}, 32'd3);
        chk("fwd_data", fwd_data, 32'h00000333);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fwd_flush", {31'd0, fwd_valid}, 32'd0);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
